// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, type-field locator and the
// extractor state enumeration.
package noc_pkg;

   localparam logic [1:0] FLIT_IDLE = 2'b00;
   localparam logic [1:0] FLIT_HEAD = 2'b01;
   localparam logic [1:0] FLIT_BODY = 2'b10;
   localparam logic [1:0] FLIT_TAIL = 2'b11;

   // The two-bit type field always sits at the top of the flit.
   function automatic int type_msb(input int flit_width);
      return flit_width - 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DRAIN,
      HOLD
   } state_t;

endpackage

// File: rtl/packet_extractor_if.sv
// Flit-in / packet-out handshake bundle for packet_extractor.
// slave is the extractor's view, master is the upstream/downstream side.
interface packet_extractor_if #(
   parameter int FLIT_WIDTH     = 16,
   parameter int MAX_BODY_FLITS = 4,
   parameter int BODY_CNT_WIDTH = $clog2(MAX_BODY_FLITS + 1)
);
   logic [FLIT_WIDTH-1:0]                i_flit;
   logic                                 i_flit_valid;
   logic                                 o_flit_ready;
   logic                                 o_pkt_valid;
   logic                                 i_pkt_ready;
   logic [FLIT_WIDTH-1:0]                o_head_flit;
   logic [MAX_BODY_FLITS*FLIT_WIDTH-1:0] o_body_flits;
   logic [BODY_CNT_WIDTH-1:0]            o_body_count;
   logic [FLIT_WIDTH-1:0]                o_tail_flit;
   logic                                 o_error;

   modport slave (
      input  i_flit, i_flit_valid, i_pkt_ready,
      output o_flit_ready, o_pkt_valid, o_head_flit, o_body_flits,
             o_body_count, o_tail_flit, o_error
   );

   modport master (
      output i_flit, i_flit_valid, i_pkt_ready,
      input  o_flit_ready, o_pkt_valid, o_head_flit, o_body_flits,
             o_body_count, o_tail_flit, o_error
   );
endinterface

// File: rtl/packet_extractor_flit_classifier.sv
// Combinational flit-type decoder; shared between the extractor and the
// packet builder.
module flit_classifier
   import noc_pkg::*;
(
   input  logic [1:0] i_type,
   output logic       o_is_head,
   output logic       o_is_body,
   output logic       o_is_tail,
   output logic       o_is_idle
);
   assign o_is_head = (i_type == FLIT_HEAD);
   assign o_is_body = (i_type == FLIT_BODY);
   assign o_is_tail = (i_type == FLIT_TAIL);
   assign o_is_idle = (i_type == FLIT_IDLE);
endmodule

// File: rtl/packet_extractor.sv
// Assembles head/body*/tail flit streams into parallel packets and flags
// framing errors; one packet is held on the output until handshaken.
module packet_extractor
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH     = 16,
   parameter int MAX_BODY_FLITS = 4,
   parameter int BODY_CNT_WIDTH = $clog2(MAX_BODY_FLITS + 1)
) (
   input logic                clk,
   input logic                rst,
   packet_extractor_if.slave  bus
);
   localparam int TYPE_MSB = type_msb(FLIT_WIDTH);
   localparam logic [BODY_CNT_WIDTH-1:0] MAX_CNT = BODY_CNT_WIDTH'(MAX_BODY_FLITS);

   state_t                    r_state;
   state_t                    w_state_next;
   logic [FLIT_WIDTH-1:0]     r_head;
   logic [FLIT_WIDTH-1:0]     r_body [MAX_BODY_FLITS];
   logic [BODY_CNT_WIDTH-1:0] r_count;
   logic [FLIT_WIDTH-1:0]     r_out_head;
   logic [FLIT_WIDTH-1:0]     r_out_tail;
   logic [FLIT_WIDTH-1:0]     r_out_body [MAX_BODY_FLITS];
   logic [BODY_CNT_WIDTH-1:0] r_out_count;
   logic                      r_error;

   logic w_is_head, w_is_body, w_is_tail, w_is_idle;
   logic w_accept, w_framed;
   logic w_store_head, w_store_body, w_latch, w_error_next;

   flit_classifier u_classifier (
      .i_type    (bus.i_flit[TYPE_MSB -: 2]),
      .o_is_head (w_is_head),
      .o_is_body (w_is_body),
      .o_is_tail (w_is_tail),
      .o_is_idle (w_is_idle)
   );

   // IDLE-type flits are consumed but never reach the FSM decisions.
   assign w_accept = bus.i_flit_valid && (r_state != HOLD);
   assign w_framed = w_accept && !w_is_idle;

   always_comb begin
      w_state_next = r_state;
      w_store_head = 1'b0;
      w_store_body = 1'b0;
      w_latch      = 1'b0;
      w_error_next = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_framed && w_is_head) begin
               w_store_head = 1'b1;
               w_state_next = COLLECT;
            end else if (w_framed) begin
               w_error_next = 1'b1;
            end
         end
         COLLECT: begin
            if (w_framed && w_is_head) begin
               w_error_next = 1'b1;
               w_store_head = 1'b1;
            end else if (w_framed && w_is_body) begin
               if (r_count == MAX_CNT) begin
                  w_error_next = 1'b1;
                  w_state_next = DRAIN;
               end else begin
                  w_store_body = 1'b1;
               end
            end else if (w_framed && w_is_tail) begin
               w_latch      = 1'b1;
               w_state_next = HOLD;
            end
         end
         DRAIN: begin
            if (w_framed && w_is_tail) begin
               w_state_next = IDLE;
            end else if (w_framed && w_is_head) begin
               w_error_next = 1'b1;
               w_store_head = 1'b1;
               w_state_next = COLLECT;
            end
         end
         HOLD: begin
            if (bus.i_pkt_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_head      <= '0;
         r_count     <= '0;
         r_out_head  <= '0;
         r_out_tail  <= '0;
         r_out_count <= '0;
         r_error     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_error <= w_error_next;
         if (w_store_head) begin
            r_head  <= bus.i_flit;
            r_count <= '0;
         end else if (w_store_body) begin
            r_count <= r_count + BODY_CNT_WIDTH'(1);
         end
         if (w_latch) begin
            r_out_head  <= r_head;
            r_out_tail  <= bus.i_flit;
            r_out_count <= r_count;
         end
      end
   end

   // Per-slot buffer and output register; slots past the count latch as zero.
   for (genvar gi = 0; gi < MAX_BODY_FLITS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_body[gi]     <= '0;
            r_out_body[gi] <= '0;
         end else begin
            if (w_store_body && (r_count == BODY_CNT_WIDTH'(gi)))
               r_body[gi] <= bus.i_flit;
            if (w_latch)
               r_out_body[gi] <= (BODY_CNT_WIDTH'(gi) < r_count) ? r_body[gi] : '0;
         end
      end
      assign bus.o_body_flits[gi*FLIT_WIDTH +: FLIT_WIDTH] = r_out_body[gi];
   end

   assign bus.o_flit_ready = (r_state != HOLD);
   assign bus.o_pkt_valid  = (r_state == HOLD);
   assign bus.o_head_flit  = r_out_head;
   assign bus.o_tail_flit  = r_out_tail;
   assign bus.o_body_count = r_out_count;
   assign bus.o_error      = r_error;

endmodule

// File: tb/tb_packet_extractor.sv
// Directed bench for packet_extractor at 16-bit/4-body and 32-bit/7-body
// configurations sharing one clock and reset.
module tb_packet_extractor;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_mis;

   packet_extractor_if #(.FLIT_WIDTH(16), .MAX_BODY_FLITS(4)) bus_a ();
   packet_extractor_if #(.FLIT_WIDTH(32), .MAX_BODY_FLITS(7)) bus_b ();

   packet_extractor #(.FLIT_WIDTH(16), .MAX_BODY_FLITS(4)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave)
   );
   packet_extractor #(.FLIT_WIDTH(32), .MAX_BODY_FLITS(7)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed packets and error pulses, sampled mid-cycle.
   int          pkt_a, err_a, pkt_b, err_b;
   logic [15:0] cap_a_head, cap_a_tail;
   logic [63:0] cap_a_body;
   logic [2:0]  cap_a_count;
   logic [31:0] cap_b_head, cap_b_tail;
   logic [223:0] cap_b_body;
   logic [2:0]  cap_b_count;

   initial begin
      pkt_a = 0; err_a = 0; pkt_b = 0; err_b = 0;
   end

   always @(negedge clk) begin
      #1;
      if (rst) begin
         if (bus_a.o_error) err_a++;
         if (bus_b.o_error) err_b++;
         if (bus_a.o_pkt_valid && bus_a.i_pkt_ready) begin
            pkt_a++;
            cap_a_head  = bus_a.o_head_flit;
            cap_a_tail  = bus_a.o_tail_flit;
            cap_a_body  = bus_a.o_body_flits;
            cap_a_count = bus_a.o_body_count;
         end
         if (bus_b.o_pkt_valid && bus_b.i_pkt_ready) begin
            pkt_b++;
            cap_b_head  = bus_b.o_head_flit;
            cap_b_tail  = bus_b.o_tail_flit;
            cap_b_body  = bus_b.o_body_flits;
            cap_b_count = bus_b.o_body_count;
         end
      end
   end

   task automatic send_a(input logic [15:0] f);
      int n;
      @(negedge clk);
      bus_a.i_flit = f; bus_a.i_flit_valid = 1'b1; n = 0;
      while (bus_a.o_flit_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n == 20) begin n_vec++; n_mis++; $display("FAIL send_a_stall flit=%h ready=%b required 1", f, bus_a.o_flit_ready); end
      @(posedge clk);
   endtask

   task automatic send_b(input logic [31:0] f);
      int n;
      @(negedge clk);
      bus_b.i_flit = f; bus_b.i_flit_valid = 1'b1; n = 0;
      while (bus_b.o_flit_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n == 20) begin n_vec++; n_mis++; $display("FAIL send_b_stall flit=%h ready=%b required 1", f, bus_b.o_flit_ready); end
      @(posedge clk);
   endtask

   task automatic idle_all();
      @(negedge clk);
      bus_a.i_flit_valid = 1'b0;
      bus_b.i_flit_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_vec++; if (bus_a.o_pkt_valid !== 1'b0) begin n_mis++; $display("FAIL rst_pkt_valid got=%b want=0", bus_a.o_pkt_valid); end
      n_vec++; if (bus_a.o_error !== 1'b0) begin n_mis++; $display("FAIL rst_error got=%b want=0", bus_a.o_error); end
      n_vec++; if (bus_a.o_body_count !== 3'd0) begin n_mis++; $display("FAIL rst_count got=%0d want=0", bus_a.o_body_count); end
      n_vec++; if (bus_a.o_head_flit !== 16'h0) begin n_mis++; $display("FAIL rst_head got=%h want=0000", bus_a.o_head_flit); end
      n_vec++; if (bus_a.o_body_flits !== 64'h0) begin n_mis++; $display("FAIL rst_body got=%h want=0", bus_a.o_body_flits); end
      n_vec++; if (bus_a.o_tail_flit !== 16'h0) begin n_mis++; $display("FAIL rst_tail got=%h want=0000", bus_a.o_tail_flit); end
      n_vec++; if (bus_a.o_flit_ready !== 1'b1) begin n_mis++; $display("FAIL rst_flit_ready got=%b want=1", bus_a.o_flit_ready); end
      @(negedge clk); rst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_full_packet();
      int p0, e0;
      p0 = pkt_a; e0 = err_a;
      bus_a.i_pkt_ready = 1'b1;
      send_a(16'h4000); send_a(16'h8001); send_a(16'h8002);
      send_a(16'h8003); send_a(16'h8004); send_a(16'hC005);
      idle_all(); #1;
      n_vec++; if (bus_a.o_pkt_valid !== 1'b1) begin n_mis++; $display("FAIL full_valid_latency got=%b want=1", bus_a.o_pkt_valid); end
      @(negedge clk); #1;
      n_vec++; if (bus_a.o_pkt_valid !== 1'b0) begin n_mis++; $display("FAIL full_valid_pulse got=%b want=0", bus_a.o_pkt_valid); end
      repeat (2) @(negedge clk);
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL full_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_head !== 16'h4000) begin n_mis++; $display("FAIL full_head got=%h want=4000", cap_a_head); end
      n_vec++; if (cap_a_body !== 64'h8004_8003_8002_8001) begin n_mis++; $display("FAIL full_body got=%h want=8004800380028001", cap_a_body); end
      n_vec++; if (cap_a_count !== 3'd4) begin n_mis++; $display("FAIL full_count got=%0d want=4", cap_a_count); end
      n_vec++; if (cap_a_tail !== 16'hC005) begin n_mis++; $display("FAIL full_tail got=%h want=C005", cap_a_tail); end
      n_vec++; if (err_a !== e0) begin n_mis++; $display("FAIL full_no_error got=%0d want=%0d", err_a, e0); end
      $display("full packet: head=%h count=%0d tail=%h", cap_a_head, cap_a_count, cap_a_tail);
   endtask

   task automatic test_backpressure();
      int p0;
      p0 = pkt_a;
      bus_a.i_pkt_ready = 1'b0;
      send_a(16'h4010); send_a(16'hC011);
      idle_all();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++; if (bus_a.o_pkt_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid[%0d] got=%b want=1", i, bus_a.o_pkt_valid); end
         n_vec++; if (bus_a.o_flit_ready !== 1'b0) begin n_mis++; $display("FAIL bp_ready[%0d] got=%b want=0", i, bus_a.o_flit_ready); end
         n_vec++; if (bus_a.o_head_flit !== 16'h4010) begin n_mis++; $display("FAIL bp_head[%0d] got=%h want=4010", i, bus_a.o_head_flit); end
         n_vec++; if (bus_a.o_body_flits !== 64'h0) begin n_mis++; $display("FAIL bp_body[%0d] got=%h want=0", i, bus_a.o_body_flits); end
         n_vec++; if (bus_a.o_body_count !== 3'd0) begin n_mis++; $display("FAIL bp_count[%0d] got=%0d want=0", i, bus_a.o_body_count); end
         @(negedge clk);
      end
      bus_a.i_pkt_ready = 1'b1;
      @(negedge clk); #1;
      n_vec++; if (bus_a.o_pkt_valid !== 1'b0) begin n_mis++; $display("FAIL bp_release_valid got=%b want=0", bus_a.o_pkt_valid); end
      n_vec++; if (bus_a.o_flit_ready !== 1'b1) begin n_mis++; $display("FAIL bp_release_ready got=%b want=1", bus_a.o_flit_ready); end
      @(negedge clk);
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL bp_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_tail !== 16'hC011) begin n_mis++; $display("FAIL bp_tail got=%h want=C011", cap_a_tail); end
      $display("backpressure packet: head=%h tail=%h", cap_a_head, cap_a_tail);
   endtask

   task automatic test_stray_body();
      int p0, e0;
      p0 = pkt_a; e0 = err_a;
      send_a(16'h8001);
      idle_all(); #1;
      n_vec++; if (bus_a.o_error !== 1'b1) begin n_mis++; $display("FAIL stray_err_timing got=%b want=1", bus_a.o_error); end
      send_a(16'h4000); send_a(16'h8001); send_a(16'hC002);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (err_a !== e0 + 1) begin n_mis++; $display("FAIL stray_err_cnt got=%0d want=%0d", err_a, e0 + 1); end
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL stray_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_count !== 3'd1) begin n_mis++; $display("FAIL stray_count got=%0d want=1", cap_a_count); end
      n_vec++; if (cap_a_body !== 64'h0000_0000_0000_8001) begin n_mis++; $display("FAIL stray_body got=%h want=0000000000008001", cap_a_body); end
      $display("stray body: errors=%0d packet tail=%h", err_a - e0, cap_a_tail);
   endtask

   task automatic test_overflow();
      int p0, e0;
      p0 = pkt_a; e0 = err_a;
      send_a(16'h4000);
      for (int k = 1; k <= 5; k++) send_a(16'h8000 + 16'(k));
      idle_all(); #1;
      n_vec++; if (bus_a.o_error !== 1'b1) begin n_mis++; $display("FAIL ovf_err_timing got=%b want=1", bus_a.o_error); end
      send_a(16'hC009);
      send_a(16'h4020); send_a(16'hC021);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (err_a !== e0 + 1) begin n_mis++; $display("FAIL ovf_err_cnt got=%0d want=%0d", err_a, e0 + 1); end
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL ovf_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_head !== 16'h4020) begin n_mis++; $display("FAIL ovf_head got=%h want=4020", cap_a_head); end
      n_vec++; if (cap_a_count !== 3'd0) begin n_mis++; $display("FAIL ovf_count got=%0d want=0", cap_a_count); end
      n_vec++; if (cap_a_tail !== 16'hC021) begin n_mis++; $display("FAIL ovf_tail got=%h want=C021", cap_a_tail); end
      $display("overflow: errors=%0d next head=%h", err_a - e0, cap_a_head);
   endtask

   task automatic test_head_abort();
      int p0, e0;
      p0 = pkt_a; e0 = err_a;
      send_a(16'h4000); send_a(16'h8001); send_a(16'h4030);
      idle_all(); #1;
      n_vec++; if (bus_a.o_error !== 1'b1) begin n_mis++; $display("FAIL abort_err_timing got=%b want=1", bus_a.o_error); end
      send_a(16'h8031); send_a(16'hC032);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (err_a !== e0 + 1) begin n_mis++; $display("FAIL abort_err_cnt got=%0d want=%0d", err_a, e0 + 1); end
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL abort_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_head !== 16'h4030) begin n_mis++; $display("FAIL abort_head got=%h want=4030", cap_a_head); end
      n_vec++; if (cap_a_body !== 64'h0000_0000_0000_8031) begin n_mis++; $display("FAIL abort_body got=%h want=0000000000008031", cap_a_body); end
      n_vec++; if (cap_a_count !== 3'd1) begin n_mis++; $display("FAIL abort_count got=%0d want=1", cap_a_count); end
      $display("head abort: head=%h count=%0d", cap_a_head, cap_a_count);
   endtask

   task automatic test_idle_flits();
      int p0, e0;
      p0 = pkt_a; e0 = err_a;
      send_a(16'h4040); send_a(16'h0123); send_a(16'h8041); send_a(16'h0AAA); send_a(16'hC042);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (err_a !== e0) begin n_mis++; $display("FAIL idle_err_cnt got=%0d want=%0d", err_a, e0); end
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL idle_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_body !== 64'h0000_0000_0000_8041) begin n_mis++; $display("FAIL idle_body got=%h want=0000000000008041", cap_a_body); end
      n_vec++; if (cap_a_count !== 3'd1) begin n_mis++; $display("FAIL idle_count got=%0d want=1", cap_a_count); end
      $display("idle flits: head=%h count=%0d", cap_a_head, cap_a_count);
   endtask

   task automatic test_reset_collect();
      int p0, e0;
      send_a(16'h4050); send_a(16'h8051);
      idle_all(); #2; rst = 1'b0; #1;
      n_vec++; if (bus_a.o_head_flit !== 16'h0) begin n_mis++; $display("FAIL rstc_head got=%h want=0000", bus_a.o_head_flit); end
      n_vec++; if (bus_a.o_tail_flit !== 16'h0) begin n_mis++; $display("FAIL rstc_tail got=%h want=0000", bus_a.o_tail_flit); end
      n_vec++; if (bus_a.o_body_flits !== 64'h0) begin n_mis++; $display("FAIL rstc_body got=%h want=0", bus_a.o_body_flits); end
      n_vec++; if (bus_a.o_body_count !== 3'd0) begin n_mis++; $display("FAIL rstc_count got=%0d want=0", bus_a.o_body_count); end
      @(negedge clk); rst = 1'b1;
      p0 = pkt_a; e0 = err_a;
      send_a(16'hC0FF);
      idle_all(); #1;
      n_vec++; if (bus_a.o_error !== 1'b1) begin n_mis++; $display("FAIL rstc_lost_partial got=%b want=1", bus_a.o_error); end
      send_a(16'h4060); send_a(16'h8061); send_a(16'hC062);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL rstc_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_head !== 16'h4060) begin n_mis++; $display("FAIL rstc_head2 got=%h want=4060", cap_a_head); end
      n_vec++; if (cap_a_body !== 64'h0000_0000_0000_8061) begin n_mis++; $display("FAIL rstc_body2 got=%h want=0000000000008061", cap_a_body); end
      n_vec++; if (err_a !== e0 + 1) begin n_mis++; $display("FAIL rstc_err_cnt got=%0d want=%0d", err_a, e0 + 1); end
      $display("reset mid-collect: next head=%h", cap_a_head);
   endtask

   task automatic test_reset_hold();
      int p0;
      p0 = pkt_a;
      bus_a.i_pkt_ready = 1'b0;
      send_a(16'h4070); send_a(16'hC071);
      idle_all(); #1;
      n_vec++; if (bus_a.o_pkt_valid !== 1'b1) begin n_mis++; $display("FAIL rsth_pre_valid got=%b want=1", bus_a.o_pkt_valid); end
      #2; rst = 1'b0; #1;
      n_vec++; if (bus_a.o_pkt_valid !== 1'b0) begin n_mis++; $display("FAIL rsth_valid got=%b want=0", bus_a.o_pkt_valid); end
      n_vec++; if (bus_a.o_flit_ready !== 1'b1) begin n_mis++; $display("FAIL rsth_ready got=%b want=1", bus_a.o_flit_ready); end
      n_vec++; if (bus_a.o_head_flit !== 16'h0) begin n_mis++; $display("FAIL rsth_head got=%h want=0000", bus_a.o_head_flit); end
      @(negedge clk); rst = 1'b1; bus_a.i_pkt_ready = 1'b1;
      send_a(16'h4080); send_a(16'h8081); send_a(16'h8082); send_a(16'hC083);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (pkt_a !== p0 + 1) begin n_mis++; $display("FAIL rsth_pkt_cnt got=%0d want=%0d", pkt_a, p0 + 1); end
      n_vec++; if (cap_a_head !== 16'h4080) begin n_mis++; $display("FAIL rsth_head2 got=%h want=4080", cap_a_head); end
      n_vec++; if (cap_a_body !== 64'h0000_0000_8082_8081) begin n_mis++; $display("FAIL rsth_body2 got=%h want=0000000080828081", cap_a_body); end
      n_vec++; if (cap_a_count !== 3'd2) begin n_mis++; $display("FAIL rsth_count2 got=%0d want=2", cap_a_count); end
      n_vec++; if (cap_a_tail !== 16'hC083) begin n_mis++; $display("FAIL rsth_tail2 got=%h want=C083", cap_a_tail); end
      $display("reset in hold: next head=%h count=%0d", cap_a_head, cap_a_count);
   endtask

   task automatic test_wide();
      int p0, e0;
      logic [31:0] exp;
      p0 = pkt_b; e0 = err_b;
      bus_b.i_pkt_ready = 1'b1;
      send_b(32'h4000_00A0);
      for (int k = 0; k < 7; k++) send_b(32'h8000_00B0 + 32'(k));
      send_b(32'hC000_00C0);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (pkt_b !== p0 + 1) begin n_mis++; $display("FAIL wide_pkt_cnt got=%0d want=%0d", pkt_b, p0 + 1); end
      n_vec++; if (cap_b_count !== 3'd7) begin n_mis++; $display("FAIL wide_count got=%0d want=7", cap_b_count); end
      for (int k = 0; k < 7; k++) begin
         exp = 32'h8000_00B0 + 32'(k);
         n_vec++; if (cap_b_body[k*32 +: 32] !== exp) begin n_mis++; $display("FAIL wide_slot[%0d] got=%h want=%h", k, cap_b_body[k*32 +: 32], exp); end
      end
      n_vec++; if (cap_b_tail !== 32'hC000_00C0) begin n_mis++; $display("FAIL wide_tail got=%h want=C00000C0", cap_b_tail); end
      // Eight bodies overflow the 7-slot buffer.
      send_b(32'h4000_00D0);
      for (int k = 0; k < 8; k++) send_b(32'h8000_00E0 + 32'(k));
      send_b(32'hC000_00F0);
      send_b(32'h4000_0100); send_b(32'h8000_0101); send_b(32'h8000_0102); send_b(32'hC000_0103);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (err_b !== e0 + 1) begin n_mis++; $display("FAIL wide_err_cnt got=%0d want=%0d", err_b, e0 + 1); end
      n_vec++; if (pkt_b !== p0 + 2) begin n_mis++; $display("FAIL wide_pkt_cnt2 got=%0d want=%0d", pkt_b, p0 + 2); end
      n_vec++; if (cap_b_head !== 32'h4000_0100) begin n_mis++; $display("FAIL wide_head2 got=%h want=40000100", cap_b_head); end
      n_vec++; if (cap_b_count !== 3'd2) begin n_mis++; $display("FAIL wide_count2 got=%0d want=2", cap_b_count); end
      n_vec++; if (cap_b_body[63:0] !== 64'h8000_0102_8000_0101) begin n_mis++; $display("FAIL wide_body2 got=%h want=8000010280000101", cap_b_body[63:0]); end
      n_vec++; if (cap_b_body[223:64] !== 160'h0) begin n_mis++; $display("FAIL wide_unused_slots got=%h want=0", cap_b_body[223:64]); end
      // Asynchronous reset while collecting on the wide instance.
      send_b(32'h4000_0200); send_b(32'h8000_0201);
      idle_all(); #2; rst = 1'b0; #1;
      n_vec++; if (bus_b.o_head_flit !== 32'h0) begin n_mis++; $display("FAIL wide_rst_head got=%h want=0", bus_b.o_head_flit); end
      n_vec++; if (bus_b.o_body_flits !== 224'h0) begin n_mis++; $display("FAIL wide_rst_body got=%h want=0", bus_b.o_body_flits); end
      @(negedge clk); rst = 1'b1;
      send_b(32'h4000_0300); send_b(32'h8000_0301); send_b(32'hC000_0302);
      idle_all(); repeat (3) @(negedge clk);
      n_vec++; if (cap_b_head !== 32'h4000_0300) begin n_mis++; $display("FAIL wide_rst_head2 got=%h want=40000300", cap_b_head); end
      n_vec++; if (cap_b_count !== 3'd1) begin n_mis++; $display("FAIL wide_rst_count2 got=%0d want=1", cap_b_count); end
      n_vec++; if (cap_b_tail !== 32'hC000_0302) begin n_mis++; $display("FAIL wide_rst_tail2 got=%h want=C0000302", cap_b_tail); end
      $display("wide: packets=%0d errors=%0d last head=%h", pkt_b - p0, err_b - e0, cap_b_head);
   endtask

   initial begin
      n_vec = 0; n_mis = 0;
      rst = 1'b0;
      bus_a.i_flit = '0; bus_a.i_flit_valid = 1'b0; bus_a.i_pkt_ready = 1'b1;
      bus_b.i_flit = '0; bus_b.i_flit_valid = 1'b0; bus_b.i_pkt_ready = 1'b1;
      test_reset();
      test_full_packet();
      test_backpressure();
      test_stray_body();
      test_overflow();
      test_head_abort();
      test_idle_flits();
      test_reset_collect();
      test_reset_hold();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
